// File: rtl/md_sequencer_if.sv
// ID->EXE / EXE->MEM signal bundle between the pipeline and the multiply/divide sequencer.
interface md_sequencer_if;
   logic        EXE_valid;
   logic [3:0]  md_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        MEM_allow_in;
   logic        cancel;
   logic        EXE_over;
   logic        md_busy;
   logic        md_done;
   logic [31:0] md_hi;
   logic [31:0] md_lo;

   modport master (
      output EXE_valid, md_op, src1, src2, MEM_allow_in, cancel,
      input  EXE_over, md_busy, md_done, md_hi, md_lo
   );

   modport slave (
      input  EXE_valid, md_op, src1, src2, MEM_allow_in, cancel,
      output EXE_over, md_busy, md_done, md_hi, md_lo
   );
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO: radix-2 shift-add multiply or
// restoring divide on operand magnitudes over 32 cycles, then a sign-fix cycle.
module md_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter logic [31:0] DBZ_LO = 32'hFFFFFFFF
) (
   input logic           clk,
   input logic           reset,
   md_sequencer_if.slave bus
);

   if (WIDTH != 32) begin : g_width_check
      $error("md_sequencer supports WIDTH=32 only");
   end

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        is_mul, neg_q, neg_r, dbz;
   logic [31:0] opa, opb, raw_src1;
   logic [63:0] acc;
   logic [31:0] hi_q, lo_q;

   logic        accept, dec_mul, dec_signed;
   logic [31:0] abs1, abs2;
   logic [32:0] mul_sum, rem_sh;
   logic [31:0] rem_sub;
   logic        div_ge;
   logic [63:0] mul_next, div_next, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // Priority decode keeps behaviour defined even for an illegal multi-hot md_op
   always_comb begin
      dec_mul    = bus.md_op[3] | bus.md_op[2];
      dec_signed = bus.md_op[3] | (~bus.md_op[2] & bus.md_op[1]);
      abs1       = (dec_signed && bus.src1[31]) ? 32'd0 - bus.src1 : bus.src1;
      abs2       = (dec_signed && bus.src2[31]) ? 32'd0 - bus.src2 : bus.src2;
      accept     = (state == IDLE) & bus.EXE_valid & (|bus.md_op) & ~bus.cancel;
   end

   // Multiply: opa = multiplicand, opb = multiplier shifting right.
   // Divide:   opa = dividend shifting left into rem, opb = divisor; acc = {rem, quo}.
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + {1'b0, (opb[0] ? opa : 32'd0)};
      mul_next = {mul_sum, acc[31:1]};
      rem_sh   = {acc[63:32], opa[31]};
      div_ge   = rem_sh >= {1'b0, opb};
      rem_sub  = rem_sh[31:0] - opb;
      div_next = {(div_ge ? rem_sub : rem_sh[31:0]), acc[30:0], div_ge};
      prod_fix = neg_q ? 64'd0 - acc : acc;
      quo_fix  = neg_q ? 32'd0 - acc[31:0] : acc[31:0];
      rem_fix  = neg_r ? 32'd0 - acc[63:32] : acc[63:32];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (cnt == 5'd31) state_nxt = SIGN;
         SIGN:    state_nxt = DONE;
         DONE:    if (bus.MEM_allow_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.cancel) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         is_mul   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dbz      <= 1'b0;
         opa      <= '0;
         opb      <= '0;
         raw_src1 <= '0;
         acc      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               cnt      <= '0;
               acc      <= '0;
               is_mul   <= dec_mul;
               neg_q    <= dec_signed & (bus.src1[31] ^ bus.src2[31]);
               neg_r    <= dec_signed & bus.src1[31];
               dbz      <= ~dec_mul & (bus.src2 == 32'd0);
               opa      <= abs1;
               opb      <= abs2;
               raw_src1 <= bus.src1;
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (is_mul) begin
                  acc <= mul_next;
                  opb <= opb >> 1;
               end else begin
                  acc <= div_next;
                  opa <= opa << 1;
               end
            end
            SIGN: if (!bus.cancel) begin
               if (is_mul) begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end else if (dbz) begin
                  hi_q <= raw_src1;
                  lo_q <= DBZ_LO;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.md_busy  = (state == CALC) || (state == SIGN);
   assign bus.md_done  = (state == DONE);
   assign bus.md_hi    = hi_q;
   assign bus.md_lo    = lo_q;
   assign bus.EXE_over = bus.EXE_valid & (~(|bus.md_op) | (state == DONE)) & ~bus.cancel;

   a_md_op_onehot: assert property (@(posedge clk) disable iff (reset)
      !bus.EXE_valid || $onehot0(bus.md_op));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed plus randomized checks of md_sequencer against a native-arithmetic HI/LO model.
module tb_md_sequencer;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   md_sequencer_if bus ();

   md_sequencer #(
      .WIDTH (32),
      .DBZ_LO(32'hFFFFFFFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b0100;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0001;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference {hi, lo} from plain 64-bit arithmetic
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return 64'(sa * sb);
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [63:0] exp;
      int          done_at;
      int          early_over;
      int          hold_bad;
      logic [31:0] hi0, lo0;
      exp = model(op, a, b);
      @(negedge clk);
      bus.EXE_valid    = 1'b1;
      bus.md_op        = op;
      bus.src1         = a;
      bus.src2         = b;
      bus.MEM_allow_in = 1'b0;
      bus.cancel       = 1'b0;
      #1;
      check({tag, "_over_at_accept"}, 64'(bus.EXE_over), 64'd0);
      done_at    = 0;
      early_over = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         bus.src1 = $urandom;
         bus.src2 = $urandom;
         if (n == 5) check({tag, "_busy"}, 64'(bus.md_busy), 64'd1);
         if (bus.md_done) begin
            done_at = n;
            break;
         end
         if (bus.EXE_over) early_over++;
      end
      check({tag, "_latency"}, 64'(done_at), 64'd34);
      check({tag, "_early_over"}, 64'(early_over), 64'd0);
      check({tag, "_hilo"}, {bus.md_hi, bus.md_lo}, exp);
      check({tag, "_over_done"}, 64'(bus.EXE_over), 64'd1);
      hi0 = bus.md_hi;
      lo0 = bus.md_lo;
      hold_bad = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         bus.src1 = $urandom;
         bus.src2 = $urandom;
         if (!bus.md_done || !bus.EXE_over || bus.md_hi !== hi0 || bus.md_lo !== lo0)
            hold_bad++;
      end
      check({tag, "_hold"}, 64'(hold_bad), 64'd0);
      bus.MEM_allow_in = 1'b1;
      @(negedge clk);
      check({tag, "_release"}, {62'd0, bus.md_done, bus.md_busy}, 64'd0);
      bus.EXE_valid    = 1'b0;
      bus.md_op        = 4'b0000;
      bus.MEM_allow_in = 1'b0;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b, hi_prev, lo_prev;
      int          early_done;
      total = 0;
      bad   = 0;

      reset            = 1'b1;
      bus.EXE_valid    = 1'b0;
      bus.md_op        = 4'b0000;
      bus.src1         = '0;
      bus.src2         = '0;
      bus.MEM_allow_in = 1'b0;
      bus.cancel       = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_flags", {61'd0, bus.md_busy, bus.md_done, bus.EXE_over}, 64'd0);
      check("reset_hilo", {bus.md_hi, bus.md_lo}, 64'd0);

      // Non-md instruction completes combinationally and never starts the engine
      bus.EXE_valid = 1'b1;
      bus.md_op     = 4'b0000;
      #1;
      check("nonmd_over", 64'(bus.EXE_over), 64'd1);
      bus.cancel = 1'b1;
      #1;
      check("nonmd_over_cancel", 64'(bus.EXE_over), 64'd0);
      bus.cancel = 1'b0;
      @(negedge clk);
      check("nonmd_stays_idle", {62'd0, bus.md_busy, bus.md_done}, 64'd0);
      bus.EXE_valid = 1'b0;

      run_op("mult_neg3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7, 0);
      check("mult_neg3x7_const", {bus.md_hi, bus.md_lo}, 64'hFFFFFFFF_FFFFFFEB);
      run_op("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      check("multu_max_const", {bus.md_hi, bus.md_lo}, 64'hFFFFFFFE_00000001);
      run_op("div_neg7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 0);
      check("div_neg7_2_const", {bus.md_hi, bus.md_lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("divu_100_7",   OP_DIVU,  32'd100, 32'd7, 0);
      check("divu_100_7_const", {bus.md_hi, bus.md_lo}, 64'h00000002_0000000E);
      run_op("divu_by_zero", OP_DIVU,  32'h00001234, 32'd0, 0);
      check("divu_by_zero_const", {bus.md_hi, bus.md_lo}, 64'h00001234_FFFFFFFF);
      run_op("div_by_zero",  OP_DIV,   32'h80000005, 32'd0, 0);
      run_op("div_overflow", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5);
      check("div_overflow_const", {bus.md_hi, bus.md_lo}, 64'h00000000_80000000);

      // Cancel mid-iteration: engine drops to IDLE, HI/LO keep the previous result
      hi_prev = bus.md_hi;
      lo_prev = bus.md_lo;
      @(negedge clk);
      bus.EXE_valid = 1'b1;
      bus.md_op     = OP_MULT;
      bus.src1      = 32'h12345678;
      bus.src2      = 32'h9ABCDEF0;
      early_done    = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus.md_done) early_done++;
      end
      check("cancel_busy_before", 64'(bus.md_busy), 64'd1);
      bus.cancel = 1'b1;
      #1;
      check("cancel_over", 64'(bus.EXE_over), 64'd0);
      @(negedge clk);
      check("cancel_idle", {62'd0, bus.md_busy, bus.md_done}, 64'd0);
      check("cancel_no_done", 64'(early_done), 64'd0);
      check("cancel_hilo_kept", {bus.md_hi, bus.md_lo}, {hi_prev, lo_prev});
      bus.cancel    = 1'b0;
      bus.EXE_valid = 1'b0;
      bus.md_op     = 4'b0000;
      run_op("div_after_cancel", OP_DIV, 32'hFFFFFF9C, 32'd9, 0);

      for (int i = 0; i < 16; i++) begin
         op = 4'b1000 >> $urandom_range(0, 3);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'h80000000;
            3: b = 32'hFFFFFFFF;
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
